if_id_decode: RTL
=================

Name: if_id_decode

Overview:
Registered instruction-decode stage between instruction fetch and the immediate extender / register file. Accepts fetched instruction words with their PC over a valid/ready handshake. Splits each word into MIPS fields and produces the 16-bit immediate plus the sign/zero-extend select that the downstream extender consumes. A two-entry skid buffer keeps in_ready registered, so a downstream stall never creates a combinational ready path into fetch.

Parameters:
PC_WIDTH, 32, width of the PC carried alongside each instruction
CNT_W, 16, width of the stall counter (used only when PERF_CNT_EN is defined)

Ports:
clk  input  1  stage clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents a valid instruction
in_ready  output  1  stage can accept a beat; registered, equals !skid_valid
in_instr  input  32  fetched instruction word
in_pc  input  PC_WIDTH  PC of in_instr
flush  input  1  synchronous kill of all held beats (branch/jump redirect)
out_valid  output  1  decoded beat available
out_ready  input  1  downstream accepts the decoded beat
out_pc  output  PC_WIDTH  PC of the decoded beat
out_opcode  output  6  instr[31:26]
out_rs  output  5  instr[25:21]
out_rt  output  5  instr[20:16]
out_rd  output  5  instr[15:11]
out_shamt  output  5  instr[10:6]
out_funct  output  6  instr[5:0]
out_imm  output  16  instr[15:0]; feeds the extender
out_sext  output  1  1 = sign-extend out_imm, 0 = zero-extend
out_jtarget  output  26  instr[25:0]
out_illegal  output  1  opcode outside the supported set

Behaviour:
- Reset (rst_n low, asynchronous): main_valid=0, skid_valid=0, every out_* = 0 (out_sext=0), in_ready=1 while reset is asserted and after release.
- Decode happens at capture. Stored fields are registered, and outputs come straight from the main register.
- Latency: a beat accepted at edge N is visible with out_valid=1 after edge N (one cycle).
- Accept = in_valid && in_ready. Transfer = out_valid && out_ready.
- Accept with main empty, or main transferring this cycle and skid empty: beat loads into main.
- Accept while main is full and not transferring: beat loads into skid. in_ready drops next cycle.
- Transfer with skid full: skid moves to main, skid_valid clears, in_ready rises next cycle. No new beat is accepted in that cycle because in_ready was 0.
- Transfer with skid empty and no accept: main_valid clears.
- Output order equals input order. No beat is duplicated or lost except by flush.
- out_* fields hold stable while out_valid=1 and out_ready=0.
- flush=1: main_valid and skid_valid clear at the edge, and any beat accepted in the same cycle is discarded. Flush has priority over accept and transfer. out_valid=0 and in_ready=1 next cycle. Field registers may retain stale values.
- out_sext=0 for opcodes 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui. out_sext=1 for all other opcodes, including illegal ones.
- Supported opcodes: 0x00, 0x02, 0x03, 0x04, 0x05, 0x08–0x0F, 0x23, 0x2B. Any other opcode sets out_illegal=1. The beat still flows normally; the stage never stalls itself on an illegal opcode.
- in_valid=1 while in_ready=0: fetch must hold in_instr/in_pc stable. The stage ignores the beat until in_ready=1.

Optional Feature:
- Macro: PERF_CNT_EN.
- When defined: adds output port stall_cnt [CNT_W-1:0].
  - Increments each cycle with out_valid=1 and out_ready=0.
  - Saturates at all-ones.
  - Resets to 0 on rst_n low.
  - Not cleared by flush.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset: pulse rst_n low asynchronously mid-cycle while holding two beats → out_valid=0, out_sext=0 and in_ready=1 immediately. After release, first new beat appears one cycle after accept.
- addi: in_instr=0x2128FFFC, pc=0x00400000, out_ready=1 → next cycle out_opcode=0x08, rs=9, rt=8, imm=0xFFFC, sext=1, illegal=0, out_pc=0x00400000.
- ori: in_instr=0x350800FF → out_opcode=0x0D, imm=0x00FF, sext=0. Repeat with lui 0x3C081234 → sext=0, imm=0x1234.
- Backpressure: out_ready=0, offer beats at pc 0x0, 0x4, 0x8 back-to-back → 0x0 in main, 0x4 in skid, in_ready=0, 0x8 held. Raise out_ready → outputs 0x0, 0x4, 0x8 on consecutive transfers, in_ready returns to 1. With PERF_CNT_EN, stall_cnt equals the stall cycles.
- Flush: main and skid full, flush=1 concurrent with in_valid=1 → next cycle out_valid=0, in_ready=1. The concurrent beat never appears at the output.
- Illegal: in_instr=0xFC000000 → out_illegal=1, out_sext=1, beat transfers normally. Then 0x8D090004 (lw) → illegal=0, sext=1.

Source files
------------

// File: rtl/if_id_decode_if.sv
// Fetch-to-decode and decode-to-extender handshake bundle for the IF/ID stage.
interface if_id_decode_if #(
    parameter int PC_WIDTH = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [PC_WIDTH-1:0] in_pc;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [PC_WIDTH-1:0] out_pc;
    logic [5:0]          out_opcode;
    logic [4:0]          out_rs;
    logic [4:0]          out_rt;
    logic [4:0]          out_rd;
    logic [4:0]          out_shamt;
    logic [5:0]          out_funct;
    logic [15:0]         out_imm;
    logic                out_sext;
    logic [25:0]         out_jtarget;
    logic                out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm, out_sext, out_jtarget, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rs, out_rt, out_rd,
               out_shamt, out_funct, out_imm, out_sext, out_jtarget, out_illegal
    );
endinterface

// File: rtl/if_id_decode.sv
// Registered MIPS IF/ID decode stage with a two-entry skid buffer (registered in_ready).
// Optional PERF_CNT_EN adds a saturating downstream-stall counter on port stall_cnt.
module if_id_decode #(
    parameter int PC_WIDTH = 32,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    if_id_decode_if.slave bus
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);
    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         instr;
        logic                sext;
        logic                illegal;
    } beat_t;

    // Extend-select and legality are resolved at capture so the output side is pure register.
    function automatic beat_t decode(input logic [31:0] instr, input logic [PC_WIDTH-1:0] pc);
        beat_t b;
        logic [5:0] op;
        op        = instr[31:26];
        b.pc      = pc;
        b.instr   = instr;
        b.sext    = !(op inside {[6'h0C:6'h0F]});
        b.illegal = !(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, [6'h08:6'h0F], 6'h23, 6'h2B});
        return b;
    endfunction

    beat_t main_q, skid_q, dec;
    logic  main_valid, skid_valid;
    logic  accept, xfer;

    assign dec    = decode(bus.in_instr, bus.in_pc);
    assign accept = bus.in_valid && !skid_valid;
    assign xfer   = main_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // in_ready is low here, so only the skid-to-main drain can happen.
            if (xfer) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || xfer) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end else if (xfer) begin
            main_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = !skid_valid;
    assign bus.out_valid   = main_valid;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_opcode  = main_q.instr[31:26];
    assign bus.out_rs      = main_q.instr[25:21];
    assign bus.out_rt      = main_q.instr[20:16];
    assign bus.out_rd      = main_q.instr[15:11];
    assign bus.out_shamt   = main_q.instr[10:6];
    assign bus.out_funct   = main_q.instr[5:0];
    assign bus.out_imm     = main_q.instr[15:0];
    assign bus.out_jtarget = main_q.instr[25:0];
    assign bus.out_sext    = main_q.sext;
    assign bus.out_illegal = main_q.illegal;

`ifdef PERF_CNT_EN
    // Survives flush on purpose: it measures downstream backpressure, not pipeline contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (main_valid && !bus.out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule
